// File: rtl/svc_rv_stage_mem_hs_pkg.sv
// Shared encodings for the MEM stage: result-source selects, trap codes,
// access sizes and the misalignment rule.
package svc_rv_stage_mem_hs_pkg;

  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_MEM = 3'd1;
  localparam logic [2:0] RES_PC4 = 3'd2;
  localparam logic [2:0] RES_TGT = 3'd3;
  localparam logic [2:0] RES_M   = 3'd4;

  localparam logic [1:0] TRAP_NONE          = 2'b00;
  localparam logic [1:0] TRAP_LDST_MISALIGN = 2'b10;
  localparam logic [1:0] TRAP_LDST_FAULT    = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Doubleword alignment only matters on a 64-bit datapath.
  function automatic logic ldst_misalign(input logic [1:0] size, input logic [2:0] lo,
                                         input logic is64);
    case (size)
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return is64 & (|lo);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/svc_rv_stage_mem_hs_if.sv
// Data-memory request/response channel: valid/ready request, unconditional response.
interface svc_rv_stage_mem_hs_if #(parameter int XLEN = 32);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic [XLEN/8-1:0]   req_wstrb;
  logic                rsp_valid;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_err;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  input  req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/svc_rv_stage_mem_hs_fmt.sv
// Byte-lane formatting: store data/strobe replication and load extraction with
// sign/zero extension (LB/LH/LW/LD/LBU/LHU/LWU).
module svc_rv_stage_mem_hs_fmt
  import svc_rv_stage_mem_hs_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   addr_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] wdata,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] ld_data
);

  logic [NB-1:0]   base;
  logic [XLEN-1:0] sh;

  always_comb begin
    wdata = st_data;
    base  = '1;
    case (funct3[1:0])
      SZ_B:    begin wdata = {NB{st_data[7:0]}};         base = NB'(1);  end
      SZ_H:    begin wdata = {(NB/2){st_data[15:0]}};    base = NB'(3);  end
      SZ_W:    begin wdata = {(NB/4){st_data[31:0]}};    base = NB'(15); end
      default: begin wdata = st_data;                    base = '1;      end
    endcase
  end

  assign wstrb = base << addr_off;

  // Bring the addressed lane down to bit 0, then extend.
  assign sh = rsp_data >> {addr_off, 3'b000};

  always_comb begin
    ld_data = sh;
    case (funct3)
      3'b000:  ld_data = XLEN'($signed(sh[7:0]));
      3'b001:  ld_data = XLEN'($signed(sh[15:0]));
      3'b010:  ld_data = XLEN'($signed(sh[31:0]));
      3'b100:  ld_data = XLEN'(sh[7:0]);
      3'b101:  ld_data = XLEN'(sh[15:0]);
      3'b110:  ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/svc_rv_stage_mem_hs.sv
// RISC-V MEM stage for variable-latency data memory: issues one access at a
// time, stalls upstream while it is outstanding, and owns the MEM/WB register.
module svc_rv_stage_mem_hs
  import svc_rv_stage_mem_hs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_mem,
  input  logic                  reg_write_mem,
  input  logic                  mem_read_mem,
  input  logic                  mem_write_mem,
  input  logic [2:0]            funct3_mem,
  input  logic [4:0]            rd_mem,
  input  logic [2:0]            res_src_mem,
  input  logic [XLEN-1:0]       alu_result_mem,
  input  logic [XLEN-1:0]       rs2_data_mem,
  input  logic [XLEN-1:0]       pc_plus4_mem,
  input  logic [XLEN-1:0]       jb_target_mem,
  input  logic [XLEN-1:0]       m_result_mem,
  input  logic                  trap_mem,
  input  logic [1:0]            trap_code_mem,
  input  logic                  wb_stall,
  output logic                  mem_busy,
  output logic [XLEN-1:0]       result_mem,
  svc_rv_stage_mem_hs_if.master dmem,
  output logic                  valid_wb,
  output logic                  reg_write_wb,
  output logic                  trap_wb,
  output logic [4:0]            rd_wb,
  output logic [2:0]            res_src_wb,
  output logic [1:0]            trap_code_wb,
  output logic [XLEN-1:0]       result_wb
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_HOLD} state_t;

  state_t          state, state_n;
  logic            is_ldst, misalign, misalign_trap, access, is_ld, req_valid;
  logic            buf_err, err_sel, fault, wb_trap;
  logic [1:0]      wb_code;
  logic [XLEN-1:0] fmt_ld, buf_data, ld_sel;

  assign is_ldst       = valid_mem & (mem_read_mem | mem_write_mem);
  assign misalign      = ldst_misalign(funct3_mem[1:0], alu_result_mem[2:0], XLEN == 64);
  assign misalign_trap = is_ldst & ~trap_mem & misalign;
  assign access        = is_ldst & ~trap_mem & ~misalign;
  assign is_ld         = mem_read_mem;

  // Request fields come straight from EX/MEM, which mem_busy freezes.
  assign dmem.req_valid = req_valid;
  assign dmem.req_we    = ~is_ld;
  assign dmem.req_addr  = {alu_result_mem[XLEN-1:OW], {OW{1'b0}}};

  svc_rv_stage_mem_hs_fmt #(.XLEN(XLEN)) u_fmt (
    .funct3   (funct3_mem),
    .addr_off (alu_result_mem[OW-1:0]),
    .st_data  (rs2_data_mem),
    .rsp_data (dmem.rsp_data),
    .wdata    (dmem.req_wdata),
    .wstrb    (dmem.req_wstrb),
    .ld_data  (fmt_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req_valid) state_n = dmem.req_ready ? (is_ld ? S_RSP : S_IDLE) : S_REQ;
      S_REQ:   if (dmem.req_ready) state_n = is_ld ? S_RSP : (wb_stall ? S_HOLD : S_IDLE);
      S_RSP:   if (dmem.rsp_valid) state_n = wb_stall ? S_HOLD : S_IDLE;
      S_HOLD:  if (!wb_stall) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Once raised in REQ, req_valid stays up until ready regardless of wb_stall.
  always_comb begin
    req_valid = 1'b0;
    mem_busy  = 1'b0;
    case (state)
      S_IDLE: begin
        req_valid = access & ~wb_stall;
        mem_busy  = access & ~(req_valid & dmem.req_ready & ~is_ld);
      end
      S_REQ: begin
        req_valid = 1'b1;
        mem_busy  = ~(dmem.req_ready & ~is_ld & ~wb_stall);
      end
      S_RSP:   mem_busy = ~(dmem.rsp_valid & ~wb_stall);
      S_HOLD:  mem_busy = wb_stall;
      default: mem_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data <= '0;
      buf_err  <= 1'b0;
    end else if (state == S_RSP && dmem.rsp_valid) begin
      buf_data <= fmt_ld;
      buf_err  <= dmem.rsp_err;
    end
  end

  assign ld_sel  = (state == S_HOLD) ? buf_data : fmt_ld;
  assign err_sel = (state == S_HOLD) ? buf_err : ((state == S_RSP) & dmem.rsp_err);
  assign fault   = access & is_ld & err_sel;
  assign wb_trap = (valid_mem & trap_mem) | misalign_trap | fault;

  always_comb begin
    if (valid_mem & trap_mem) wb_code = trap_code_mem;
    else if (misalign_trap)   wb_code = TRAP_LDST_MISALIGN;
    else if (fault)           wb_code = TRAP_LDST_FAULT;
    else                      wb_code = TRAP_NONE;
  end

  always_comb begin
    case (res_src_mem)
      RES_M:   result_mem = m_result_mem;
      RES_PC4: result_mem = pc_plus4_mem;
      RES_TGT: result_mem = jb_target_mem;
      default: result_mem = alu_result_mem;
    endcase
  end

  // MEM/WB: hold on wb_stall, bubble while busy, otherwise take the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_wb     <= 1'b0;
      reg_write_wb <= 1'b0;
      trap_wb      <= 1'b0;
      rd_wb        <= '0;
      res_src_wb   <= '0;
      trap_code_wb <= TRAP_NONE;
      result_wb    <= '0;
    end else if (!wb_stall) begin
      if (mem_busy) begin
        valid_wb     <= 1'b0;
        reg_write_wb <= 1'b0;
        trap_wb      <= 1'b0;
      end else begin
        valid_wb     <= valid_mem;
        reg_write_wb <= valid_mem & reg_write_mem & ~wb_trap;
        trap_wb      <= wb_trap;
        rd_wb        <= rd_mem;
        res_src_wb   <= res_src_mem;
        trap_code_wb <= wb_code;
        result_wb    <= (res_src_mem == RES_MEM) ? ld_sel : result_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && is_ldst && XLEN == 32) assert (funct3_mem[1:0] != SZ_D);
  end

endmodule

// File: tb/tb_svc_rv_stage_mem_hs.sv
// Directed bench for the MEM stage: one XLEN=32 and one XLEN=64 instance share
// stimulus; use64 steers valid_mem to the instance under test.
module tb_svc_rv_stage_mem_hs;

  logic clk = 1'b0;
  logic rst, use64;
  logic valid_mem, reg_write_mem, mem_read_mem, mem_write_mem, trap_mem, wb_stall;
  logic [2:0]  funct3, res_src;
  logic [4:0]  rd;
  logic [1:0]  trap_code_mem;
  logic [63:0] alu, rs2, pc4, tgt, mres;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_data;
  logic        v32, v64;

  logic        busy32, vwb32, rwwb32, trwb32;
  logic [4:0]  rdwb32;
  logic [2:0]  rswb32;
  logic [1:0]  tcwb32;
  logic [31:0] rm32, rwb32;
  logic        busy64, vwb64, rwwb64, trwb64;
  logic [4:0]  rdwb64;
  logic [2:0]  rswb64;
  logic [1:0]  tcwb64;
  logic [63:0] rm64, rwb64;

  int checks = 0;
  int failures = 0;
  int nbusy;

  always #5 clk = ~clk;

  assign v32 = valid_mem & ~use64;
  assign v64 = valid_mem & use64;

  svc_rv_stage_mem_hs_if #(.XLEN(32)) if32 ();
  svc_rv_stage_mem_hs_if #(.XLEN(64)) if64 ();
  assign if32.req_ready = req_ready;
  assign if32.rsp_valid = rsp_valid;
  assign if32.rsp_data  = rsp_data[31:0];
  assign if32.rsp_err   = rsp_err;
  assign if64.req_ready = req_ready;
  assign if64.rsp_valid = rsp_valid;
  assign if64.rsp_data  = rsp_data;
  assign if64.rsp_err   = rsp_err;

  svc_rv_stage_mem_hs #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .valid_mem(v32), .reg_write_mem(reg_write_mem),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .funct3_mem(funct3),
    .rd_mem(rd), .res_src_mem(res_src), .alu_result_mem(alu[31:0]),
    .rs2_data_mem(rs2[31:0]), .pc_plus4_mem(pc4[31:0]), .jb_target_mem(tgt[31:0]),
    .m_result_mem(mres[31:0]), .trap_mem(trap_mem), .trap_code_mem(trap_code_mem),
    .wb_stall(wb_stall), .mem_busy(busy32), .result_mem(rm32), .dmem(if32),
    .valid_wb(vwb32), .reg_write_wb(rwwb32), .trap_wb(trwb32), .rd_wb(rdwb32),
    .res_src_wb(rswb32), .trap_code_wb(tcwb32), .result_wb(rwb32)
  );

  svc_rv_stage_mem_hs #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .valid_mem(v64), .reg_write_mem(reg_write_mem),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .funct3_mem(funct3),
    .rd_mem(rd), .res_src_mem(res_src), .alu_result_mem(alu),
    .rs2_data_mem(rs2), .pc_plus4_mem(pc4), .jb_target_mem(tgt),
    .m_result_mem(mres), .trap_mem(trap_mem), .trap_code_mem(trap_code_mem),
    .wb_stall(wb_stall), .mem_busy(busy64), .result_mem(rm64), .dmem(if64),
    .valid_wb(vwb64), .reg_write_wb(rwwb64), .trap_wb(trwb64), .rd_wb(rdwb64),
    .res_src_wb(rswb64), .trap_code_wb(tcwb64), .result_wb(rwb64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_mem = 0; reg_write_mem = 0; mem_read_mem = 0; mem_write_mem = 0;
    trap_mem = 0; trap_code_mem = 0; funct3 = 0; res_src = 0; rd = 0;
    req_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_data = 0; wb_stall = 0;
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [4:0] r, input logic [63:0] a, input logic [63:0] d);
    valid_mem = 1; mem_read_mem = ld; mem_write_mem = st; funct3 = f3; rd = r;
    reg_write_mem = ld; res_src = ld ? 3'd1 : 3'd0; alu = a; rs2 = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; use64 = 0; clr();
    alu = 0; rs2 = 0; pc4 = 0; tgt = 0; mres = 0;
    repeat (2) step();
    #1;
    chk("rst_vwb32", vwb32, 0);
    chk("rst_busy32", busy32, 0);
    chk("rst_reqv32", if32.req_valid, 0);
    chk("rst_tc32", tcwb32, 0);
    chk("rst_res32", rwb32, 0);
    chk("rst_vwb64", vwb64, 0);
    rst = 0;
    step();

    // SW, ready high: zero stall, WB next cycle
    op(0, 1, 3'b010, 0, 64'h100, 64'hDEADBEEF); req_ready = 1; #1;
    chk("sw_reqv", if32.req_valid, 1);
    chk("sw_we", if32.req_we, 1);
    chk("sw_wstrb", if32.req_wstrb, 4'hF);
    chk("sw_wdata", if32.req_wdata, 32'hDEADBEEF);
    chk("sw_addr", if32.req_addr, 32'h100);
    chk("sw_busy", busy32, 0);
    step(); clr(); #1;
    chk("sw_vwb", vwb32, 1);
    chk("sw_rwwb", rwwb32, 0);
    chk("sw_trwb", trwb32, 0);
    step(); #1;
    chk("sw_vwb_once", vwb32, 0);

    // LB 0x103: ready at cycle 2, response at cycle 5, wb_stall pulse in REQ
    nbusy = 0;
    op(1, 0, 3'b000, 5'd5, 64'h103, 0);
    for (int c = 0; c < 6; c++) begin
      req_ready = (c == 2);
      rsp_valid = (c == 5);
      rsp_data  = (c == 5) ? 64'h80FFFFFF : 64'h0;
      wb_stall  = (c == 1);
      #1;
      if (busy32) nbusy++;
      chk($sformatf("lb_reqv_c%0d", c), if32.req_valid, (c <= 2));
      step();
    end
    clr(); #1;
    chk("lb_busy_cycles", nbusy, 5);
    chk("lb_vwb", vwb32, 1);
    chk("lb_rwwb", rwwb32, 1);
    chk("lb_rd", rdwb32, 5);
    chk("lb_res", rwb32, 32'hFFFFFF80);

    // LH misaligned
    op(1, 0, 3'b001, 5'd7, 64'h101, 0); req_ready = 1; #1;
    chk("lh_mis_reqv", if32.req_valid, 0);
    chk("lh_mis_busy", busy32, 0);
    step(); clr(); #1;
    chk("lh_mis_vwb", vwb32, 1);
    chk("lh_mis_trap", trwb32, 1);
    chk("lh_mis_code", tcwb32, 2);
    chk("lh_mis_rw", rwwb32, 0);

    // Non-access forwarding
    valid_mem = 1; reg_write_mem = 1; rd = 9; res_src = 3'd2; pc4 = 64'h44; alu = 64'h77;
    mres = 64'h99; #1;
    chk("fwd_pc4", rm32, 32'h44);
    step(); res_src = 3'd4; #1;
    chk("fwd_pc4_wb", rwb32, 32'h44);
    chk("fwd_rw", rwwb32, 1);
    chk("fwd_rd", rdwb32, 9);
    chk("fwd_m", rm32, 32'h99);
    step(); clr();

    // Upstream trap passes through
    op(1, 0, 3'b010, 5'd3, 64'h200, 0); trap_mem = 1; trap_code_mem = 2'b01; req_ready = 1; #1;
    chk("trp_reqv", if32.req_valid, 0);
    step(); clr(); #1;
    chk("trp_wb", trwb32, 1);
    chk("trp_code", tcwb32, 1);
    chk("trp_rw", rwwb32, 0);

    // Response under wb_stall -> HOLD, released two cycles later
    op(1, 0, 3'b010, 5'd4, 64'h200, 0); req_ready = 1; #1;
    chk("hold_hs_busy", busy32, 1);
    step(); req_ready = 0; rsp_valid = 1; rsp_data = 64'h12345678; wb_stall = 1; #1;
    chk("hold_rsp_busy", busy32, 1);
    step(); rsp_valid = 0; rsp_data = 64'hFFFFFFFF; #1;
    chk("hold_wait_busy", busy32, 1);
    chk("hold_vwb_c2", vwb32, 0);
    step(); wb_stall = 0; #1;
    chk("hold_rel_busy", busy32, 0);
    chk("hold_vwb_c3", vwb32, 0);
    step(); clr(); #1;
    chk("hold_vwb_c4", vwb32, 1);
    chk("hold_res", rwb32, 32'h12345678);
    step(); #1;
    chk("hold_vwb_c5", vwb32, 0);

    // Bus fault
    op(1, 0, 3'b010, 5'd6, 64'h300, 0); req_ready = 1;
    step(); req_ready = 0; rsp_valid = 1; rsp_err = 1; rsp_data = 64'h55; #1;
    chk("err_busy", busy32, 0);
    step(); clr(); #1;
    chk("err_trap", trwb32, 1);
    chk("err_code", tcwb32, 3);
    chk("err_rw", rwwb32, 0);

    // Reset while in RSP, then a stray response
    op(1, 0, 3'b010, 5'd8, 64'h400, 0); req_ready = 1;
    step(); clr(); alu = 0; rst = 1; #1;
    chk("rstm_busy_rsp", busy32, 1);
    step(); rst = 0; rsp_valid = 1; rsp_data = 64'hAAAA; #1;
    chk("rstm_busy", busy32, 0);
    chk("rstm_reqv", if32.req_valid, 0);
    chk("rstm_vwb", vwb32, 0);
    chk("rstm_res", rwb32, 0);
    chk("rstm_tc", tcwb32, 0);
    step(); clr(); #1;
    chk("rstm_vwb2", vwb32, 0);
    chk("rstm_rw2", rwwb32, 0);

    // XLEN=64
    use64 = 1;
    op(1, 0, 3'b110, 5'd10, 64'h104, 0); req_ready = 1; #1;
    chk("lwu_addr", if64.req_addr, 64'h100);
    step(); req_ready = 0; rsp_valid = 1; rsp_data = 64'h89ABCDEF_00000000;
    step(); clr(); #1;
    chk("lwu_res", rwb64, 64'h00000000_89ABCDEF);
    chk("lwu_vwb", vwb64, 1);

    op(1, 0, 3'b010, 5'd12, 64'h104, 0); req_ready = 1;
    step(); req_ready = 0; rsp_valid = 1; rsp_data = 64'h80000000_00000000;
    step(); clr(); #1;
    chk("lw64_res", rwb64, 64'hFFFFFFFF_80000000);

    op(0, 1, 3'b011, 0, 64'h108, 64'h01234567_89ABCDEF); req_ready = 1; #1;
    chk("sd_wstrb", if64.req_wstrb, 8'hFF);
    chk("sd_wdata", if64.req_wdata, 64'h01234567_89ABCDEF);
    chk("sd_busy", busy64, 0);
    step(); clr(); #1;
    chk("sd_vwb", vwb64, 1);

    op(0, 1, 3'b010, 0, 64'h104, 64'hDEADBEEF); req_ready = 1; #1;
    chk("sw64_wstrb", if64.req_wstrb, 8'hF0);
    chk("sw64_wdata", if64.req_wdata, 64'hDEADBEEF_DEADBEEF);
    step(); clr();

    op(1, 0, 3'b011, 5'd11, 64'h104, 0); req_ready = 1; #1;
    chk("ld_mis_reqv", if64.req_valid, 0);
    step(); clr(); #1;
    chk("ld_mis_code", tcwb64, 2);
    chk("ld_mis_rw", rwwb64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/svc_rv_stage_mem_hs.md
# svc_rv_stage_mem_hs

RISC-V MEM stage for variable-latency data memory, between EX/MEM and WB in the pipelined core. It issues loads and stores over a valid/ready request channel plus a response channel, and stalls the upstream pipeline while an access is outstanding. It formats load and store data for XLEN=32 or XLEN=64 (LD/SD/LWU), flags misalignment and bus-fault traps, and owns the registered MEM/WB boundary.

## Interface
- XLEN, 32, datapath/address width; 32 or 64
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_mem, reg_write_mem, mem_read_mem, mem_write_mem  in  1 each  EX/MEM qualifiers
- funct3_mem  in  3 / rd_mem  in  5 / res_src_mem  in  3  instruction fields
- alu_result_mem, rs2_data_mem, pc_plus4_mem, jb_target_mem, m_result_mem  in  XLEN  EX results; alu_result_mem is the address
- trap_mem  in  1 / trap_code_mem  in  2  upstream trap
- wb_stall  in  1  WB cannot accept
- mem_busy  out  1  holds EX/MEM and earlier stages
- result_mem  out  XLEN  non-load forwarding value (RES_M/RES_PC4/RES_TGT/else ALU)
- dmem_req_valid out 1, dmem_req_ready in 1, dmem_req_we out 1, dmem_req_addr out XLEN (aligned to XLEN/8), dmem_req_wdata out XLEN, dmem_req_wstrb out XLEN/8
- dmem_rsp_valid in 1, dmem_rsp_data in XLEN, dmem_rsp_err in 1
- valid_wb, reg_write_wb, trap_wb  out  1 / rd_wb  out  5 / res_src_wb  out  3 / trap_code_wb  out  2 / result_wb  out  XLEN (selected result, load data when RES_MEM)

## Operation
- Access = valid_mem & (mem_read_mem | mem_write_mem) & !trap_mem & !misalign.
- Misalign by size funct3[1:0]: half addr[0]; word |addr[1:0]; double (XLEN=64) |addr[2:0]. Misalign produces no request and passes to WB with reg_write_wb=0, trap_code TRAP_LDST_MISALIGN. trap_mem passes through unchanged.
- Store: wdata/wstrb replicated by lane from addr low bits. Load: response sign/zero-extended per funct3 (LB, LH, LW, LD, LBU, LHU, LWU). Size 2'b11 is illegal at XLEN=32 (assertion).
- FSM states:
  - IDLE: req_valid = access & !wb_stall.
    - Store handshake: done this cycle; WB loads.
    - Load handshake: go RSP.
    - Valid without ready: go REQ.
  - REQ: req_valid=1, request fields held stable.
    - Ready & store: WB loads if !wb_stall, else go HOLD.
    - Ready & load: go RSP.
  - RSP: req_valid=0.
    - rsp_valid: capture formatted data.
    - If !wb_stall: WB loads, go IDLE. Else go HOLD.
  - HOLD: wait for !wb_stall, then WB loads from the buffer and go IDLE.
- mem_busy = 1 in IDLE when access and no store completes this cycle, in REQ and RSP unless completing with !wb_stall, and in HOLD while wb_stall.
- dmem_rsp_err: reg_write_wb=0, trap_wb=1, trap_code TRAP_LDST_FAULT.
- MEM/WB register:
  - Loads on completion with !wb_stall; non-access instructions load when !wb_stall and !mem_busy.
  - Inserts a bubble (valid_wb=0) when !wb_stall and mem_busy.
  - Holds everything while wb_stall.

## Timing
- Reset values: state IDLE, valid_wb/reg_write_wb/trap_wb 0, trap_code_wb TRAP_NONE, other WB outputs 0, dmem_req_valid 0, mem_busy 0.
- Store with ready high in its first MEM cycle: zero stall cycles; appears in WB the next cycle.
- Load, with ready at cycle 0 and rsp_valid at cycle N≥1: mem_busy high for cycles 0..N-1; valid_wb at N+1.
- dmem_rsp_valid is ignored outside RSP, so the response cannot arrive in the handshake cycle.
- dmem_req_valid never drops before ready, including when wb_stall rises in REQ.
- Reset mid-access forces IDLE. A late response for the abandoned request is then ignored because IDLE discards rsp_valid; the memory side must be reset alongside.
- Only one access is outstanding at a time.

## Structure
- svc_rv_defs.svh holds RES_*, TRAP_*, and the new TRAP_LDST_FAULT = 2'b11.
- The FSM state enum is local to the module.
- svc_rv_ld_fmt and svc_rv_st_fmt are reused, extended for XLEN=64 doubleword/LWU. The FSM and MEM/WB register stay inline.

## Test plan
- SW x=0xDEADBEEF to 0x100, ready tied high: one req (wstrb 0xF, no stall); valid_wb next cycle, reg_write_wb=0.
- LB from 0x103, ready delayed 2 cycles, rsp 0x80FFFFFF after 3 more: busy 5 cycles; result_wb=0xFFFFFF80, req_valid steady through the wait.
- LH at 0x101: no request, trap_wb=1, TRAP_LDST_MISALIGN, reg_write_wb=0.
- XLEN=64 LWU at 0x104, rsp 0x89ABCDEF_00000000: result_wb=0x00000000_89ABCDEF. SD at 0x108: wstrb 0xFF.
- Load response during wb_stall (HOLD), release after 2 cycles: WB receives data once, valid_wb single-cycle. Response with dmem_rsp_err=1: TRAP_LDST_FAULT.
- rst in RSP, then a stray rsp_valid: state IDLE, no WB update, all outputs at reset values.
